// File: rtl/nes_controller_emulator.sv
// Responder end of the NES/SNES serial pad protocol: it snapshots a button word on host
// latch and shifts it out LSB first, active low, once per synchronised host clock rise.
module nes_controller_emulator #(
  parameter int   NUM_BITS   = 8,
  parameter logic TAIL_LEVEL = 1'b0,
  parameter int   SYNC_FF    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nes_latch_i,
  input  logic                nes_clk_i,
  input  logic [NUM_BITS-1:0] buttons_i,
  output logic                nes_data_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SYNC_FF-1:0]  latch_sync_q, clk_sync_q;
  logic                latch_prev_q, clk_prev_q;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic latch_s, clk_s, latch_fall, clk_rise;

  assign latch_s    = latch_sync_q[SYNC_FF-1];
  assign clk_s      = clk_sync_q[SYNC_FF-1];
  assign latch_fall = ~latch_s & latch_prev_q;
  assign clk_rise   = clk_s & ~clk_prev_q;

  // Host clock idles high, so its chain resets to 1 to avoid a phantom rise after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_FF-2:0], nes_latch_i};
      clk_sync_q   <= {clk_sync_q[SYNC_FF-2:0], nes_clk_i};
      latch_prev_q <= latch_s;
      clk_prev_q   <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A high latch overrides everything, including a host clock rise in the same cycle.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    if (latch_s) begin
      state_d   = LOAD;
      shreg_d   = buttons_i;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (latch_fall) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(NUM_BITS - 1)) begin
              state_d      = DONE;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nes_data_o = 1'b1;
    case (state_q)
      LOAD:    nes_data_o = ~buttons_i[0];
      SHIFT:   nes_data_o = ~shreg_q[0];
      DONE:    nes_data_o = TAIL_LEVEL;
      default: nes_data_o = 1'b1;
    endcase
  end

  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Drives an NES (8-bit) and an SNES (16-bit) responder from one shared host latch/clock
// and checks both against an abstract frame model plus hand-computed literals.
module tb_nes_controller_emulator;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_n, latch, hclk;
  logic [7:0]  btn8;
  logic [15:0] btn16;
  logic        d8, b8, f8, d16, b16, f16;

  nes_controller_emulator #(.NUM_BITS(8)) u_nes (
    .clk(clk), .rst_n(rst_n), .nes_latch_i(latch), .nes_clk_i(hclk),
    .buttons_i(btn8), .nes_data_o(d8), .busy_o(b8), .frame_done_o(f8));

  nes_controller_emulator #(.NUM_BITS(16)) u_snes (
    .clk(clk), .rst_n(rst_n), .nes_latch_i(latch), .nes_clk_i(hclk),
    .buttons_i(btn16), .nes_data_o(d16), .busy_o(b16), .frame_done_o(f16));

  // Model: 0 = idle, 1 = latch held, 2 = frame in progress / finished.
  int          m_state[2];
  logic [15:0] m_word[2];
  int          m_cnt[2];
  int          m_fd[2];
  int          fd_seen[2];
  int          tests = 0, fails = 0;
  int          cyc = 0, last_chg = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  cap8;
  logic [15:0] cap16;

  function automatic int nbits(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic logic [15:0] btn_of(input int d);
    return (d == 0) ? {8'h00, btn8} : btn16;
  endfunction

  function automatic logic exp_data(input int d);
    logic [15:0] b;
    b = btn_of(d);
    if (m_state[d] == 1) return ~b[0];
    if (m_state[d] == 2) return (m_cnt[d] < nbits(d)) ? ~m_word[d][m_cnt[d]] : 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int d);
    return (m_state[d] == 2) && (m_cnt[d] < nbits(d));
  endfunction

  task automatic check(input string name, input int d, input logic [15:0] got,
                       input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h want %0h (cycle %0d)", name, d, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (f8 === 1'b1) fd_seen[0]++;
    if (f16 === 1'b1) fd_seen[1]++;
    if (chk_en && (cyc - last_chg > 5)) begin
      check("data", 0, {15'd0, d8}, {15'd0, exp_data(0)});
      check("busy", 0, {15'd0, b8}, {15'd0, exp_busy(0)});
      check("fdone_idle", 0, {15'd0, f8}, 16'd0);
      check("data", 1, {15'd0, d16}, {15'd0, exp_data(1)});
      check("busy", 1, {15'd0, b16}, {15'd0, exp_busy(1)});
      check("fdone_idle", 1, {15'd0, f16}, 16'd0);
    end
  end

  task automatic wait_c(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lines(input logic l, input logic c);
    for (int d = 0; d < 2; d++) begin
      if (l) begin
        m_state[d] = 1;
      end else if (latch && !l) begin
        m_state[d] = 2;
        m_word[d]  = btn_of(d);
        m_cnt[d]   = 0;
      end else if (!hclk && c && m_state[d] == 2 && m_cnt[d] < nbits(d)) begin
        m_cnt[d]++;
        if (m_cnt[d] == nbits(d)) m_fd[d]++;
      end
    end
    latch    = l;
    hclk     = c;
    last_chg = cyc;
  endtask

  // Host samples the line at the end of the low phase, then the rise consumes the bit.
  task automatic pulse(input int k);
    set_lines(1'b0, 1'b0);
    wait_c(150);
    if (k < 8) cap8[k] = ~d8;
    if (k < 16) cap16[k] = ~d16;
    set_lines(1'b0, 1'b1);
    wait_c(150);
  endtask

  task automatic latch_frame();
    set_lines(1'b1, hclk);
    wait_c(300);
    cap8  = '0;
    cap16 = '0;
    set_lines(1'b0, 1'b1);
    wait_c(150);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0;
      m_cnt[d]   = 0;
    end
    last_chg = cyc;
    wait_c(3);
    check("rst_data", 0, {15'd0, d8}, 16'd1);
    check("rst_busy", 0, {15'd0, b8}, 16'd0);
    check("rst_fdone", 0, {15'd0, f8}, 16'd0);
    check("rst_data", 1, {15'd0, d16}, 16'd1);
    rst_n    = 1'b1;
    last_chg = cyc;
    wait_c(10);
  endtask

  initial begin
    rst_n = 1'b0; latch = 1'b0; hclk = 1'b1; btn8 = '0; btn16 = '0;
    cap8 = '0; cap16 = '0;
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_word[d] = '0; m_cnt[d] = 0; m_fd[d] = 0; fd_seen[d] = 0;
    end
    do_reset();
    chk_en = 1'b1;

    // NES and SNES frames in one host transaction; also pins the 3-cycle latency.
    btn8  = 8'b1000_0101;
    btn16 = 16'h0F01;
    set_lines(1'b1, 1'b1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("lat_before", 0, {15'd0, d8}, 16'd1);
    @(negedge clk);
    check("lat_after", 0, {15'd0, d8}, 16'd0);
    wait_c(300);
    cap8 = '0; cap16 = '0;
    set_lines(1'b0, 1'b1);
    wait_c(150);
    check("busy_after_fall", 0, {15'd0, b8}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      pulse(k);
      if (k == 7) begin
        check("nes_tail", 0, {15'd0, d8}, 16'd0);
        check("nes_fdone_once", 0, 16'(fd_seen[0]), 16'd1);
        check("nes_busy_end", 0, {15'd0, b8}, 16'd0);
        check("snes_busy_mid", 1, {15'd0, b16}, 16'd1);
      end
    end
    check("nes_frame", 0, {8'd0, cap8}, 16'h0085);
    check("snes_frame", 1, cap16, 16'h0F01);
    check("snes_busy_end", 1, {15'd0, b16}, 16'd0);
    check("snes_fdone_once", 1, 16'(fd_seen[1]), 16'd1);

    // Re-latch after 3 bits, latch rise coincident with a host clock rise.
    btn8 = 8'hA5; btn16 = 16'h1234;
    latch_frame();
    for (int k = 0; k < 3; k++) pulse(k);
    set_lines(1'b0, 1'b0);
    wait_c(150);
    btn8 = 8'hFF; btn16 = 16'hFFFF;
    set_lines(1'b1, 1'b1);
    wait_c(300);
    check("relatch_data", 0, {15'd0, d8}, 16'd0);
    check("relatch_busy", 0, {15'd0, b8}, 16'd0);
    check("relatch_no_fdone", 0, 16'(fd_seen[0]), 16'd1);
    cap8 = '0; cap16 = '0;
    set_lines(1'b0, 1'b1);
    wait_c(150);
    for (int k = 0; k < 16; k++) pulse(k);
    check("relatch_frame", 0, {8'd0, cap8}, 16'h00FF);
    check("relatch_fdone", 0, 16'(fd_seen[0]), 16'd2);
    check("relatch_fdone", 1, 16'(fd_seen[1]), 16'd2);

    // Buttons changing during the shift must not alter the frame.
    btn8 = 8'h01; btn16 = 16'h0001;
    latch_frame();
    btn8 = 8'h02; btn16 = 16'h0002;
    for (int k = 0; k < 16; k++) pulse(k);
    check("frozen_frame", 0, {8'd0, cap8}, 16'h0001);
    check("frozen_frame", 1, cap16, 16'h0001);

    // Reset mid-frame, then a clean frame from bit 0.
    btn8 = 8'h5A; btn16 = 16'hC3A5;
    latch_frame();
    for (int k = 0; k < 4; k++) pulse(k);
    do_reset();
    check("post_rst_data", 0, {15'd0, d8}, 16'd1);
    check("post_rst_busy", 1, {15'd0, b16}, 16'd0);
    btn8 = 8'h3C; btn16 = 16'h8001;
    latch_frame();
    for (int k = 0; k < 16; k++) pulse(k);
    check("post_rst_frame", 0, {8'd0, cap8}, 16'h003C);
    check("post_rst_frame", 1, cap16, 16'h8001);
    check("fdone_total", 0, 16'(fd_seen[0]), 16'd4);
    check("fdone_total", 1, 16'(fd_seen[1]), 16'd4);
    check("fdone_model", 0, 16'(fd_seen[0]), 16'(m_fd[0]));
    check("fdone_model", 1, 16'(fd_seen[1]), 16'(m_fd[1]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
